// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the RISC Toy pipeline: ALU control codes and MEM-stage FSM encoding.
package mem_access_stage_pkg;

  // 5-bit ALU control codes; only LD/ST are treated specially by the MEM stage
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_LD  = 5'b10011;
  localparam logic [4:0] ALU_ST  = 5'b10101;

  // MEM-stage FSM encoding
  localparam logic [0:0] MEM_IDLE = 1'b0;
  localparam logic [0:0] MEM_BUSY = 1'b1;

  // True for instructions that need a data-memory access
  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == ALU_LD) || (op == ALU_ST);
  endfunction

endpackage

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues LD/ST over a req/ack port, stalls EX while busy,
// and registers results into the MEM/WB boundary.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex_valid,
  input  logic [4:0]        ex_op,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_we,
  output logic              ex_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [DATA_W-1:0] ADDR_MASK = ~DATA_W'(3);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        cap_rd_q, cap_rd_d;
  logic              cap_we_q, cap_we_d;
  logic              req_d, dwe_d, wbv_d, wbwe_d, err_d;
  logic [4:0]        wbrd_d;
  logic [DATA_W-1:0] addr_d, wdata_d, wbdata_d;

  // Next-state, stall and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_rd_d = cap_rd_q;
    cap_we_d = cap_we_q;
    req_d    = dmem_req;
    dwe_d    = dmem_we;
    addr_d   = dmem_addr;
    wdata_d  = dmem_wdata;
    wbv_d    = 1'b0;
    wbwe_d   = 1'b0;
    wbrd_d   = wb_rd;
    wbdata_d = wb_data;
    err_d    = mem_err;
    ex_stall = 1'b0;

    if (state_q == MEM_IDLE) begin
      if (ex_valid) begin
        if (is_mem_op(ex_op)) begin
          ex_stall = 1'b1;
          state_d  = MEM_BUSY;
          cnt_d    = '0;
          req_d    = 1'b1;
          dwe_d    = (ex_op == ALU_ST);
          addr_d   = ex_alu_result & ADDR_MASK;
          wdata_d  = ex_store_data;
          cap_rd_d = ex_rd;
          cap_we_d = ex_we;
        end else begin
          wbv_d    = 1'b1;
          wbwe_d   = ex_we;
          wbrd_d   = ex_rd;
          wbdata_d = ex_alu_result;
        end
      end
    end else begin
      if (dmem_ack) begin
        // Access completes; stores retire without a register write
        state_d  = MEM_IDLE;
        req_d    = 1'b0;
        wbv_d    = 1'b1;
        wbrd_d   = cap_rd_q;
        wbwe_d   = dmem_we ? 1'b0 : cap_we_q;
        wbdata_d = dmem_we ? '0 : dmem_rdata;
      end else if (cnt_q == CNT_LAST) begin
        // Abandon the access, retire the instruction as a no-write, flag the error
        state_d  = MEM_IDLE;
        req_d    = 1'b0;
        err_d    = 1'b1;
        wbv_d    = 1'b1;
        wbrd_d   = cap_rd_q;
        wbwe_d   = 1'b0;
        wbdata_d = '0;
      end else begin
        ex_stall = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= MEM_IDLE;
      cnt_q      <= '0;
      cap_rd_q   <= '0;
      cap_we_q   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      mem_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_rd_q   <= cap_rd_d;
      cap_we_q   <= cap_we_d;
      dmem_req   <= req_d;
      dmem_we    <= dwe_d;
      dmem_addr  <= addr_d;
      dmem_wdata <= wdata_d;
      wb_valid   <= wbv_d;
      wb_we      <= wbwe_d;
      wb_rd      <= wbrd_d;
      wb_data    <= wbdata_d;
      mem_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, LD/ST, timeout, reset abort, back-to-back.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid;
  logic [4:0]  ex_op;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        ex_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_err;

  int checks = 0;
  int errors = 0;
  int req_rises = 0;
  int wb_pulses = 0;
  logic req_prev = 1'b0;

  mem_access_stage #(.DATA_W(32), .MAX_WAIT(16)) dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_stall(ex_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  // Count request launches and writeback pulses, sampled just after each edge
  always @(posedge CLK) begin
    #2;
    if (dmem_req && !req_prev) req_rises++;
    if (wb_valid) wb_pulses++;
    req_prev = dmem_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [4:0] op, input logic [31:0] res,
                         input logic [31:0] sd, input logic [4:0] rd, input logic we);
    ex_valid      = 1'b1;
    ex_op         = op;
    ex_alu_result = res;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_we         = we;
  endtask

  initial begin
    int n_req;
    int n_stall;
    logic last_stall;
    int snap_req;
    int snap_wb;

    RST = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_alu_result = '0; ex_store_data = '0;
    ex_rd = '0; ex_we = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    @(negedge CLK); @(negedge CLK);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    RST = 1'b0;

    // ADD pass-through, 1-cycle latency
    @(negedge CLK);
    present(ALU_ADD, 32'h0000_0042, 32'h0, 5'd3, 1'b1);
    #1 check("add_stall", 32'(ex_stall), 32'd0);
    @(negedge CLK);
    check("add_wbv", 32'(wb_valid), 32'd1);
    check("add_data", wb_data, 32'h42);
    check("add_rd", 32'(wb_rd), 32'd3);
    check("add_we", 32'(wb_we), 32'd1);
    check("add_req", 32'(dmem_req), 32'd0);
    ex_valid = 1'b0;
    dmem_ack = 1'b1;
    @(negedge CLK);
    check("idle_wbv", 32'(wb_valid), 32'd0);
    check("idle_wbwe", 32'(wb_we), 32'd0);
    check("idle_ack_req", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b0;

    // LD with ack two cycles after the request rises
    present(ALU_LD, 32'h0000_1007, 32'hFFFF_FFFF, 5'd4, 1'b1);
    #1 check("ld_stall0", 32'(ex_stall), 32'd1);
    check("ld_req_accept", 32'(dmem_req), 32'd0);
    @(negedge CLK);
    check("ld_req", 32'(dmem_req), 32'd1);
    check("ld_addr", dmem_addr, 32'h0000_1004);
    check("ld_dwe", 32'(dmem_we), 32'd0);
    check("ld_wbv_busy", 32'(wb_valid), 32'd0);
    check("ld_stall1", 32'(ex_stall), 32'd1);
    @(negedge CLK);
    check("ld_stall2", 32'(ex_stall), 32'd1);
    @(negedge CLK);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1 check("ld_stall_ack", 32'(ex_stall), 32'd0);
    @(negedge CLK);
    dmem_ack = 1'b0; ex_valid = 1'b0;
    check("ld_wbv", 32'(wb_valid), 32'd1);
    check("ld_data", wb_data, 32'hDEAD_BEEF);
    check("ld_wbwe", 32'(wb_we), 32'd1);
    check("ld_wbrd", 32'(wb_rd), 32'd4);
    check("ld_req_done", 32'(dmem_req), 32'd0);

    // ST with ack in the first BUSY cycle
    @(negedge CLK);
    present(ALU_ST, 32'h0000_0020, 32'h1234_5678, 5'd7, 1'b1);
    #1 check("st_stall0", 32'(ex_stall), 32'd1);
    @(negedge CLK);
    check("st_req", 32'(dmem_req), 32'd1);
    check("st_dwe", 32'(dmem_we), 32'd1);
    check("st_addr", dmem_addr, 32'h20);
    check("st_wdata", dmem_wdata, 32'h1234_5678);
    dmem_ack = 1'b1;
    #1 check("st_stall_ack", 32'(ex_stall), 32'd0);
    @(negedge CLK);
    dmem_ack = 1'b0; ex_valid = 1'b0;
    check("st_wbv", 32'(wb_valid), 32'd1);
    check("st_wbwe", 32'(wb_we), 32'd0);
    check("st_wbdata", wb_data, 32'd0);
    check("st_req_done", 32'(dmem_req), 32'd0);

    // LD that never gets an ack: timeout after 16 request cycles
    @(negedge CLK);
    present(ALU_LD, 32'h0000_0040, 32'h0, 5'd2, 1'b1);
    n_req = 0; n_stall = 0; last_stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (dmem_req) begin
        n_req++;
        last_stall = ex_stall;
        if (ex_stall) n_stall++;
      end else if (n_req > 0) begin
        break;
      end
    end
    ex_valid = 1'b0;
    check("to_req_cycles", 32'(n_req), 32'd16);
    check("to_stall_cycles", 32'(n_stall), 32'd15);
    check("to_last_stall", 32'(last_stall), 32'd0);
    check("to_err", 32'(mem_err), 32'd1);
    check("to_wbv", 32'(wb_valid), 32'd1);
    check("to_wbwe", 32'(wb_we), 32'd0);
    check("to_wbdata", wb_data, 32'd0);
    @(negedge CLK); @(negedge CLK);
    check("to_err_sticky", 32'(mem_err), 32'd1);

    // Reset while BUSY abandons the access
    present(ALU_LD, 32'h0000_0080, 32'h0, 5'd6, 1'b1);
    @(negedge CLK);
    check("rb_req", 32'(dmem_req), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("rb_req_drop", 32'(dmem_req), 32'd0);
    check("rb_wbv", 32'(wb_valid), 32'd0);
    check("rb_err", 32'(mem_err), 32'd0);
    RST = 1'b0;
    present(ALU_ADD, 32'h0000_0099, 32'h0, 5'd5, 1'b1);
    #1 check("rb_add_stall", 32'(ex_stall), 32'd0);
    @(negedge CLK);
    check("rb_add_wbv", 32'(wb_valid), 32'd1);
    check("rb_add_data", wb_data, 32'h99);
    check("rb_add_req", 32'(dmem_req), 32'd0);
    ex_valid = 1'b0;
    @(negedge CLK);

    // LD, ST, ADD back-to-back with immediate acks
    snap_req = req_rises; snap_wb = wb_pulses;
    present(ALU_LD, 32'h0000_0100, 32'h0, 5'd8, 1'b1);
    #1 check("bb_ld_stall", 32'(ex_stall), 32'd1);
    @(negedge CLK);
    check("bb_ld_addr", dmem_addr, 32'h100);
    dmem_ack = 1'b1; dmem_rdata = 32'hAAAA_5555;
    @(negedge CLK);
    dmem_ack = 1'b0;
    check("bb_ld_wbv", 32'(wb_valid), 32'd1);
    check("bb_ld_data", wb_data, 32'hAAAA_5555);
    check("bb_ld_rd", 32'(wb_rd), 32'd8);
    present(ALU_ST, 32'h0000_0206, 32'h0BAD_F00D, 5'd1, 1'b0);
    #1 check("bb_st_stall", 32'(ex_stall), 32'd1);
    @(negedge CLK);
    check("bb_st_req", 32'(dmem_req), 32'd1);
    check("bb_st_addr", dmem_addr, 32'h204);
    check("bb_st_wdata", dmem_wdata, 32'h0BAD_F00D);
    check("bb_st_wbv_busy", 32'(wb_valid), 32'd0);
    dmem_ack = 1'b1;
    @(negedge CLK);
    dmem_ack = 1'b0;
    check("bb_st_wbv", 32'(wb_valid), 32'd1);
    check("bb_st_wbwe", 32'(wb_we), 32'd0);
    present(ALU_ADD, 32'h0000_0077, 32'h0, 5'd9, 1'b1);
    #1 check("bb_add_stall", 32'(ex_stall), 32'd0);
    @(negedge CLK);
    ex_valid = 1'b0;
    check("bb_add_wbv", 32'(wb_valid), 32'd1);
    check("bb_add_data", wb_data, 32'h77);
    check("bb_add_rd", 32'(wb_rd), 32'd9);
    check("bb_add_req", 32'(dmem_req), 32'd0);
    @(negedge CLK);
    check("bb_idle_wbv", 32'(wb_valid), 32'd0);
    @(negedge CLK);
    check("bb_req_count", 32'(req_rises - snap_req), 32'd2);
    check("bb_wb_count", 32'(wb_pulses - snap_wb), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
